// File: rtl/axis_data_fifo.sv
// ---------------------------------------------------------------------------
// axis_data_fifo
//
// Single-clock first-word-fall-through FIFO for an AXI4-Stream data path.
// A beat pushed into an empty FIFO shows up on m_axis_* one cycle later.
// The output beat is held in registers, so it stays stable while stalled and
// keeps its last value while the FIFO is empty.
//
// Optional build macro:
//   AXIS_FIFO_PACKET_MODE_EN - packet (store-and-forward) mode. m_axis_tvalid
//                              is withheld until a complete packet (tlast) is
//                              stored, or until the FIFO is full. The full
//                              case releases packets longer than DEPTH so they
//                              cannot deadlock.
//
// Parameters:
//   DATA_BITS - stream data width in bits (multiple of 8, >= 8)
//   DEPTH     - entry count (power of two, >= 2)
//
// Ports:
//   aclk          - clock, all logic on the rising edge
//   areset        - asynchronous active-high reset
//   s_axis_tdata  - write data
//   s_axis_tkeep  - write byte enables, stored verbatim
//   s_axis_tlast  - write end-of-packet
//   s_axis_tvalid - write valid
//   s_axis_tready - write ready (registered, no path from m_axis_tready)
//   m_axis_tdata  - read data
//   m_axis_tkeep  - read byte enables
//   m_axis_tlast  - read end-of-packet
//   m_axis_tvalid - read valid
//   m_axis_tready - read ready
//   count         - number of beats currently stored
// ---------------------------------------------------------------------------
module axis_data_fifo #(
    parameter int unsigned DATA_BITS = 512,
    parameter int unsigned DEPTH     = 32
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [DATA_BITS-1:0]         s_axis_tdata,
    input  logic [DATA_BITS/8-1:0]       s_axis_tkeep,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [DATA_BITS-1:0]         m_axis_tdata,
    output logic [DATA_BITS/8-1:0]       m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned KW = DATA_BITS / 8;
    localparam logic [AW:0] FULL_COUNT = CW'(DEPTH);

    // Storage: intentionally not reset.
    logic [DATA_BITS-1:0] mem_data [DEPTH];
    logic [KW-1:0]        mem_keep [DEPTH];
    logic                 mem_last [DEPTH];

    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [AW:0] count_q, count_nxt;
    logic        ready_q, ready_nxt;

    logic push, pop;
    logic empty;
    logic load_out;
    logic bypass;

    assign push  = s_axis_tvalid & s_axis_tready;
    assign pop   = m_axis_tvalid & m_axis_tready;
    assign empty = (wr_ptr == rd_ptr);

    always_comb begin
        wr_ptr_nxt = wr_ptr + CW'(push);
        rd_ptr_nxt = rd_ptr + CW'(pop);

        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase

        // Full when the wrap bits differ and the address bits match.
        ready_nxt = !((wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]));

        // The output registers mirror the head entry. They reload only when
        // the head changes to a valid entry, so an emptied FIFO keeps showing
        // the last beat. If the new head is the slot being written this very
        // cycle, the write data is forwarded instead of the stale memory word.
        load_out = (pop && (count_nxt != '0)) || (empty && push);
        bypass   = push && (wr_ptr == rd_ptr_nxt);
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]] <= s_axis_tdata;
            mem_keep[wr_ptr[AW-1:0]] <= s_axis_tkeep;
            mem_last[wr_ptr[AW-1:0]] <= s_axis_tlast;
        end
    end

    always_ff @(posedge aclk) begin
        if (load_out) begin
            if (bypass) begin
                m_axis_tdata <= s_axis_tdata;
                m_axis_tkeep <= s_axis_tkeep;
                m_axis_tlast <= s_axis_tlast;
            end else begin
                m_axis_tdata <= mem_data[rd_ptr_nxt[AW-1:0]];
                m_axis_tkeep <= mem_keep[rd_ptr_nxt[AW-1:0]];
                m_axis_tlast <= mem_last[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            ready_q <= ready_nxt;
        end
    end

    // ready_q resets high so the write side opens as soon as areset drops;
    // the gate holds it low while areset is asserted.
    assign s_axis_tready = ready_q & ~areset;
    assign count         = count_q;

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [AW:0] pkt_cnt;
    logic        in_pkt;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pkt_cnt <= '0;
            in_pkt  <= 1'b0;
        end else begin
            case ({push && s_axis_tlast, pop && m_axis_tlast})
                2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
            // Once a packet has started leaving, keep presenting it until
            // its tlast beat pops, even if the full-release condition goes away.
            if (pop)
                in_pkt <= ~m_axis_tlast;
        end
    end

    assign m_axis_tvalid = (count_q != '0) &&
                           ((pkt_cnt != '0) || (count_q == FULL_COUNT) || in_pkt);
`else
    assign m_axis_tvalid = (count_q != '0);
`endif

endmodule

// File: tb/tb_axis_data_fifo.sv
module tb_axis_data_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [5:0]  count;

    axis_data_fifo #(.DATA_BITS(DW), .DEPTH(DEPTH)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .count         (count)
    );

    always #5 aclk = ~aclk;

    int    n_vec = 0;
    int    n_bad = 0;
    beat_t sb[$];
    int    mcount = 0;
    int    mpkt = 0;
    bit    min_pkt = 0;
    bit    seen_out = 0;
    beat_t last_out;
    int    max_count = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_valid();
`ifdef AXIS_FIFO_PACKET_MODE_EN
        return (mcount != 0) && ((mpkt != 0) || (mcount == DEPTH) || min_pkt);
`else
        return (mcount != 0);
`endif
    endfunction

    // One clock cycle: drive at the falling edge, check at the next falling edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic [3:0] k,
                        input logic l, input logic ordy, output bit acc);
        bit do_push, do_pop;
        beat_t b;
        s_axis_tvalid = iv;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        m_axis_tready = ordy;
        do_push = iv && (mcount != DEPTH);
        do_pop  = exp_valid() && ordy;
        acc = do_push;
        if (do_pop) begin
            b = sb.pop_front();
            last_out = b;
            seen_out = 1;
            mpkt -= b.l ? 1 : 0;
            min_pkt = !b.l;
        end
        if (do_push) begin
            sb.push_back('{d: d, k: k, l: l});
            mpkt += l ? 1 : 0;
        end
        mcount += (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        if (mcount > max_count) max_count = mcount;
        @(posedge aclk);
        @(negedge aclk);
        check("count", 64'(count), 64'(mcount));
        check("s_tready", 64'(s_axis_tready), 64'(mcount != DEPTH));
        check("m_tvalid", 64'(m_axis_tvalid), 64'(exp_valid()));
        if (exp_valid()) begin
            check("m_tdata", 64'(m_axis_tdata), 64'(sb[0].d));
            check("m_tkeep", 64'(m_axis_tkeep), 64'(sb[0].k));
            check("m_tlast", 64'(m_axis_tlast), 64'(sb[0].l));
        end else if (mcount == 0 && seen_out) begin
            check("hold_tdata", 64'(m_axis_tdata), 64'(last_out.d));
        end
    endtask

    task automatic drain(input int budget);
        bit acc;
        int n = 0;
        while (mcount != 0 && n < budget) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc);
            n++;
        end
        check("drain_done", 64'(mcount), 64'd0);
    endtask

    task automatic model_clear();
        sb.delete();
        mcount = 0;
        mpkt = 0;
        min_pkt = 0;
        seen_out = 0;
    endtask

    initial begin
        bit acc;
        int sent, cyc, pushed;
        logic [31:0] r;

        areset = 1'b1;
        s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0;
        m_axis_tready = 0;
        repeat (3) @(negedge aclk);
        check("rst_count", 64'(count), 64'd0);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        areset = 1'b0;
        #1;
        check("post_rst_s_tready", 64'(s_axis_tready), 64'd1);
        @(negedge aclk);

        // Single beat with downstream ready.
        step(1'b1, 32'hA5, 4'hF, 1'b1, 1'b1, acc);
        check("single_count", 64'(count), 64'd1);
        step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        check("single_count0", 64'(count), 64'd0);
        // Empty FIFO ignores tready and keeps showing the last beat.
        step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        step(1'b0, '0, '0, 1'b0, 1'b1, acc);

        // Fill to full with the sink stalled.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'h100 + 32'(i), 4'(i), 1'b1, 1'b0, acc);
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_s_tready", 64'(s_axis_tready), 64'd0);
        step(1'b1, 32'hDEAD, 4'h3, 1'b1, 1'b0, acc);
        check("beat33_refused", 64'(acc), 64'd0);
        step(1'b1, 32'hDEAD, 4'h3, 1'b1, 1'b1, acc);
        check("full_pop_tready", 64'(s_axis_tready), 64'd1);
        step(1'b1, 32'hDEAD, 4'h3, 1'b1, 1'b0, acc);
        check("beat33_taken", 64'(acc), 64'd1);
        drain(100);

        // Random valid/ready traffic across pointer wrap.
        sent = 0; cyc = 0; max_count = 0;
        while ((sent < 100 || mcount != 0) && cyc < 3000) begin
            r = $urandom;
            step((sent < 100) && ($urandom_range(0, 3) != 0), r, 4'(r[7:4]),
                 1'b1, $urandom_range(0, 2) == 0 ? 1'b0 : 1'b1, acc);
            if (acc) sent++;
            cyc++;
        end
        check("rand_complete", 64'(cyc < 3000), 64'd1);
        check("rand_max_count", 64'(max_count <= DEPTH), 64'd1);

`ifdef AXIS_FIFO_PACKET_MODE_EN
        // Four-beat packet is held back until its tlast beat is stored.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h400 + 32'(i), 4'hF, i == 3, 1'b1, acc);
        check("pkt4_valid", 64'(m_axis_tvalid), 64'd1);
        drain(20);

        // Forty-beat packet: released when full, all beats delivered.
        pushed = 0; cyc = 0;
        while (mcount < DEPTH && cyc < 100) begin
            step(1'b1, 32'h800 + 32'(pushed), 4'hF, pushed == 39, 1'b0, acc);
            if (acc) pushed++;
            cyc++;
        end
        check("pkt40_release", 64'(m_axis_tvalid), 64'd1);
        while ((pushed < 40 || mcount != 0) && cyc < 400) begin
            step(pushed < 40, 32'h800 + 32'(pushed), 4'hF, pushed == 39, 1'b1, acc);
            if (acc) pushed++;
            cyc++;
        end
        check("pkt40_done", 64'(pushed == 40 && mcount == 0), 64'd1);
`endif

        // Reset in the middle of traffic with ten beats stored.
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'h900 + 32'(i), 4'h1, 1'b0, 1'b0, acc);
        check("pre_rst_count", 64'(count), 64'd10);
        #2 areset = 1'b1;
        #1;
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_s_tready", 64'(s_axis_tready), 64'd0);
        s_axis_tvalid = 0;
        model_clear();
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("midrst_release_tready", 64'(s_axis_tready), 64'd1);
        @(negedge aclk);
        step(1'b1, 32'h77, 4'hA, 1'b1, 1'b0, acc);
        check("after_rst_first", 64'(m_axis_tdata), 64'h77);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
